dm_port_arbiter: RTL and testbench

//  Shares the single Data Memory port (DMWr/MemOp/MemEXT/address/din/dout) between two requesters.
//  m0 is the CPU load/store stage; m1 is the program loader/debug port.
//  Req/ack handshake per requester, round-robin grant, alignment and range checking.

---
 rtl/dm_port_arbiter_pkg.sv | 24 ++
 rtl/dm_port_arbiter_check.sv | 29 ++
 rtl/dm_port_arbiter.sv | 132 +++++++++++++
 tb/tb_dm_port_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_port_arbiter_pkg.sv
// Shared constants and types for the data-memory port arbiter.
// Memory op encodings and the data segment base match the DataMem block.
package dm_port_arbiter_pkg;

    localparam logic [1:0]  MEM_BYTE          = 2'b00;
    localparam logic [1:0]  MEM_HALF          = 2'b01;
    localparam logic [1:0]  MEM_WORD          = 2'b10;
    localparam logic [31:0] DATA_BASE_ADDRESS = 32'h1001_0000;

    typedef enum logic [1:0] {
        DMA_IDLE   = 2'b00,
        DMA_ACCESS = 2'b01,
        DMA_RESP   = 2'b10
    } dma_state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  op;
        logic        ext;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dm_req_t;

endpackage

// File: rtl/dm_port_arbiter_check.sv
// Alignment and range rules for a data-memory access; purely combinational.
module dm_access_check
    import dm_port_arbiter_pkg::*;
#(
    parameter int DM_BYTES = 4096
) (
    input  logic [1:0]  op,
    input  logic [31:0] addr,
    output logic        err
);

    localparam logic [31:0] DM_LIMIT = 32'(DM_BYTES);

    logic [31:0] offset;
    logic        misaligned;

    // Addresses below the base wrap to a huge offset and fail the range test.
    always_comb begin
        offset     = addr - DATA_BASE_ADDRESS;
        misaligned = 1'b0;
        case (op)
            MEM_HALF: misaligned = addr[0];
            MEM_WORD: misaligned = |addr[1:0];
            default:  misaligned = 1'b0;
        endcase
        err = misaligned || (offset >= DM_LIMIT);
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter for the single DataMem port: req/ack handshake,
// round-robin or fixed-priority grant, registered drive of the memory port.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int DM_BYTES   = 4096,
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_op,
    input  logic        m0_ext,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_op,
    input  logic        m1_ext,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        dm_wr,
    output logic [1:0]  dm_op,
    output logic        dm_ext,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout,
    output logic        busy
);

    dma_state_t state, state_nx;
    dm_req_t    r0, r1, win_req;
    logic       win, any_req, chk_err;
    logic       last_gnt, owner;

    assign r0      = '{we: m0_we, op: m0_op, ext: m0_ext, addr: m0_addr, wdata: m0_wdata};
    assign r1      = '{we: m1_we, op: m1_op, ext: m1_ext, addr: m1_addr, wdata: m1_wdata};
    assign any_req = m0_req | m1_req;
    assign busy    = (state != DMA_IDLE);

    // On a tie the requester that was not granted last time wins.
    always_comb begin
        win = 1'b0;
        if (m0_req && m1_req)
            win = PRIO_FIXED ? 1'b0 : ~last_gnt;
        else if (m1_req)
            win = 1'b1;
        win_req = win ? r1 : r0;
    end

    dm_access_check #(.DM_BYTES(DM_BYTES)) u_check (
        .op   (win_req.op),
        .addr (win_req.addr),
        .err  (chk_err)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= DMA_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            DMA_IDLE:   if (any_req) state_nx = chk_err ? DMA_RESP : DMA_ACCESS;
            DMA_ACCESS: state_nx = DMA_RESP;
            DMA_RESP:   state_nx = DMA_IDLE;
            default:    state_nx = DMA_IDLE;
        endcase
    end

    // ack/err/rdata are loaded only on the edge entering RESP, so they pulse for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
            owner    <= 1'b0;
            dm_wr    <= 1'b0;
            dm_op    <= '0;
            dm_ext   <= 1'b0;
            dm_addr  <= '0;
            dm_din   <= '0;
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= '0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= '0;
        end else begin
            dm_wr    <= 1'b0;
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= '0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= '0;
            case (state)
                DMA_IDLE: if (any_req) begin
                    owner    <= win;
                    last_gnt <= win;
                    dm_op    <= win_req.op;
                    dm_ext   <= win_req.ext;
                    dm_addr  <= win_req.addr;
                    dm_din   <= win_req.wdata;
                    if (chk_err) begin
                        if (win) begin m1_ack <= 1'b1; m1_err <= 1'b1; end
                        else     begin m0_ack <= 1'b1; m0_err <= 1'b1; end
                    end else begin
                        dm_wr <= win_req.we;
                    end
                end
                DMA_ACCESS: begin
                    if (owner) begin
                        m1_ack   <= 1'b1;
                        m1_rdata <= dm_wr ? '0 : dm_dout;
                    end else begin
                        m0_ack   <= 1'b1;
                        m0_rdata <= dm_wr ? '0 : dm_dout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural byte-addressed DataMem model.
module tb_dm_port_arbiter;
    import dm_port_arbiter_pkg::*;

    localparam logic [31:0] BASE = DATA_BASE_ADDRESS;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_ext, m1_req, m1_we, m1_ext;
    logic [1:0]  m0_op, m1_op;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        dm_wr, dm_ext, busy;
    logic [1:0]  dm_op;
    logic [31:0] dm_addr, dm_din, dm_dout;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.DM_BYTES(4096), .PRIO_FIXED(1'b0)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_op(m0_op), .m0_ext(m0_ext),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_op(m1_op), .m1_ext(m1_ext),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .dm_wr(dm_wr), .dm_op(dm_op), .dm_ext(dm_ext), .dm_addr(dm_addr),
        .dm_din(dm_din), .dm_dout(dm_dout), .busy(busy)
    );

    // Little-endian DataMem model: combinational read, write at posedge.
    logic [7:0] mem [0:4095];

    function automatic logic [11:0] ix(input logic [31:0] a, input int k);
        logic [31:0] o;
        o = a - BASE + 32'(k);
        return o[11:0];
    endfunction

    always @(posedge clk) begin
        if (dm_wr) begin
            mem[ix(dm_addr, 0)] <= dm_din[7:0];
            if (dm_op != MEM_BYTE) mem[ix(dm_addr, 1)] <= dm_din[15:8];
            if (dm_op == MEM_WORD) begin
                mem[ix(dm_addr, 2)] <= dm_din[23:16];
                mem[ix(dm_addr, 3)] <= dm_din[31:24];
            end
        end
    end

    always @* begin
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[ix(dm_addr, 0)];
        b1 = mem[ix(dm_addr, 1)];
        b2 = mem[ix(dm_addr, 2)];
        b3 = mem[ix(dm_addr, 3)];
        case (dm_op)
            MEM_BYTE: dm_dout = dm_ext ? {{24{b0[7]}}, b0} : {24'h0, b0};
            MEM_HALF: dm_dout = dm_ext ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
            default:  dm_dout = {b3, b2, b1, b0};
        endcase
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [1:0]  op;
        logic        ext;
        logic [31:0] off;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    task automatic drive(input vec_t v);
        if (v.port) begin
            m1_req = 1'b1; m1_we = v.we; m1_op = v.op; m1_ext = v.ext;
            m1_addr = BASE + v.off; m1_wdata = v.wdata;
        end else begin
            m0_req = 1'b1; m0_we = v.we; m0_op = v.op; m0_ext = v.ext;
            m0_addr = BASE + v.off; m0_wdata = v.wdata;
        end
    endtask

    task automatic drop(input logic port);
        if (port) m1_req = 1'b0;
        else      m0_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Latency counts negedges after the request was raised until ack is seen.
    task automatic run_txn(input vec_t v, output logic got_err, output logic [31:0] got_rd,
                           output int lat, output int wrs);
        got_err = 1'b0; got_rd = '0; lat = 0; wrs = 0;
        @(negedge clk);
        drive(v);
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (dm_wr) wrs++;
            if (v.port ? m1_ack : m0_ack) begin
                lat     = k;
                got_err = v.port ? m1_err : m0_err;
                got_rd  = v.port ? m1_rdata : m0_rdata;
                drop(v.port);
            end
        end
        if (lat == 0) drop(v.port);
    endtask

    // Both requesters raise req together; reports the negedge index of each ack.
    task automatic run_dual(output int a0, output int a1, output logic [31:0] rd1);
        vec_t w0, r1v;
        w0  = '{1'b0, 1'b1, MEM_WORD, 1'b0, 32'h20, 32'h1111_2222, 1'b0, 32'h0};
        r1v = '{1'b1, 1'b0, MEM_WORD, 1'b0, 32'h20, 32'h0,         1'b0, 32'h0};
        a0 = 0; a1 = 0; rd1 = '0;
        @(negedge clk);
        drive(w0);
        drive(r1v);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (m0_ack && a0 == 0) begin a0 = k; drop(1'b0); end
            if (m1_ack && a1 == 0) begin a1 = k; rd1 = m1_rdata; drop(1'b1); end
        end
        drop(1'b0);
        drop(1'b1);
    endtask

    initial begin
        logic        e;
        logic [31:0] rd, rd1;
        int          lat, wrs, a0, a1, acks, busys;

        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_op = 0; m0_ext = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_op = 0; m1_ext = 0; m1_addr = 0; m1_wdata = 0;

        //          port  we    op        ext   off            wdata          err   rdata
        vt[0]  = '{1'b0, 1'b1, MEM_WORD, 1'b0, 32'h8,         32'h1234_5678, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 1'b0, MEM_WORD, 1'b0, 32'h8,         32'h0,         1'b0, 32'h1234_5678};
        vt[2]  = '{1'b1, 1'b1, MEM_BYTE, 1'b0, 32'h3,         32'h1234_56AB, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 1'b0, MEM_BYTE, 1'b1, 32'h3,         32'h0,         1'b0, 32'hFFFF_FFAB};
        vt[4]  = '{1'b1, 1'b0, MEM_BYTE, 1'b0, 32'h3,         32'h0,         1'b0, 32'h0000_00AB};
        vt[5]  = '{1'b1, 1'b0, MEM_WORD, 1'b0, 32'h0,         32'h0,         1'b0, 32'hAB00_0000};
        vt[6]  = '{1'b0, 1'b0, MEM_HALF, 1'b0, 32'h1,         32'h0,         1'b1, 32'h0};
        vt[7]  = '{1'b0, 1'b1, MEM_WORD, 1'b0, 32'h1002,      32'hCAFE_F00D, 1'b1, 32'h0};
        vt[8]  = '{1'b0, 1'b0, MEM_WORD, 1'b0, 32'h1000,      32'h0,         1'b1, 32'h0};
        vt[9]  = '{1'b1, 1'b1, MEM_HALF, 1'b0, 32'hFFE,       32'h0000_BEEF, 1'b0, 32'h0};
        vt[10] = '{1'b1, 1'b0, MEM_HALF, 1'b1, 32'hFFE,       32'h0,         1'b0, 32'hFFFF_BEEF};
        vt[11] = '{1'b0, 1'b0, MEM_WORD, 1'b0, 32'hFFC,       32'h0,         1'b0, 32'hBEEF_0000};
        vt[12] = '{1'b0, 1'b0, MEM_WORD, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};
        vt[13] = '{1'b0, 1'b0, MEM_WORD, 1'b0, 32'h8,         32'h0,         1'b0, 32'h1234_5678};

        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(busy),   32'h0);
        chk("rst_dm_wr",  32'(dm_wr),  32'h0);
        chk("rst_acks",   32'({m0_ack, m1_ack}), 32'h0);
        chk("rst_addr",   dm_addr,     32'h0);
        chk("rst_rdata",  m0_rdata,    32'h0);
        rst = 1'b0;

        foreach (vt[i]) begin
            run_txn(vt[i], e, rd, lat, wrs);
            chk($sformatf("vec%0d_lat", i),   32'(lat), vt[i].exp_err ? 32'd1 : 32'd2);
            chk($sformatf("vec%0d_err", i),   32'(e),   32'(vt[i].exp_err));
            chk($sformatf("vec%0d_rdata", i), rd,       vt[i].exp_rdata);
            chk($sformatf("vec%0d_wrs", i),   32'(wrs), 32'(vt[i].we && !vt[i].exp_err));
        end

        // Tie right after reset: m0 first, m1 served three cycles later.
        do_reset();
        run_dual(a0, a1, rd1);
        chk("tie1_m0_ack", 32'(a0), 32'd2);
        chk("tie1_m1_ack", 32'(a1), 32'd5);
        chk("tie1_m1_rd",  rd1,     32'h1111_2222);

        // After m0 is granted alone, a tie goes to m1.
        run_txn(vt[13], e, rd, lat, wrs);
        chk("rr_single_lat", 32'(lat), 32'd2);
        run_dual(a0, a1, rd1);
        chk("tie2_m1_ack", 32'(a1), 32'd2);
        chk("tie2_m0_ack", 32'(a0), 32'd5);

        // Reset while a store is in ACCESS: write commits, no ack.
        @(negedge clk);
        drive('{1'b0, 1'b1, MEM_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0});
        @(negedge clk);
        chk("rsta_dm_wr", 32'(dm_wr), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("rsta_ack",  32'(m0_ack), 32'h0);
        chk("rsta_busy", 32'(busy),   32'h0);
        rst = 1'b0;
        drop(1'b0);
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) acks++;
        end
        chk("rsta_no_ack", 32'(acks), 32'h0);
        run_txn('{1'b0, 1'b0, MEM_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0}, e, rd, lat, wrs);
        chk("rsta_readback", rd, 32'hDEAD_BEEF);

        // Requester drops req one cycle after grant: access still completes once.
        @(negedge clk);
        drive('{1'b0, 1'b0, MEM_WORD, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0});
        @(negedge clk);
        drop(1'b0);
        @(negedge clk);
        chk("drop_ack",   32'(m0_ack), 32'h1);
        chk("drop_rdata", m0_rdata,    32'h1234_5678);
        acks = 0; busys = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) acks++;
            if (busy) busys++;
        end
        chk("drop_no_reack",  32'(acks),  32'h0);
        chk("drop_idle",      32'(busys), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
